// File: rtl/ssd_page_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ssd_page_scheduler                                            |
// | Purpose  : Drives a 4-digit seven-segment display from up to four 16-bit |
// |            debug pages. Handles digit scan timing, anode blanking,       |
// |            frame-boundary snapshotting and push-button page selection.   |
// | Ports    : clk, reset (async, active-high)                               |
// |            page_btn   raw push-button input                              |
// |            freeze     hold the current snapshot                          |
// |            page_valid per-page selectable mask                           |
// |            page_data0..3  page values                                    |
// |            an, seg, dp    active-low display pins (an[0] = rightmost)    |
// |            page_sel   selected page; frame_tick  frame boundary pulse    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ssd_page_scheduler #(
  parameter int SCAN_DIV  = 200000,
  parameter int BLANK_CYC = 2000,
  parameter int DEB_CYC   = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        page_btn,
  input  logic        freeze,
  input  logic [3:0]  page_valid,
  input  logic [15:0] page_data0,
  input  logic [15:0] page_data1,
  input  logic [15:0] page_data2,
  input  logic [15:0] page_data3,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  page_sel,
  output logic        frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);

  // Active-low hex glyphs, {a,b,c,d,e,f,g}
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;  // F
    endcase
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [1:0]       d;
  logic [15:0]      snap;
  logic             btn_s1;
  logic             btn_s2;
  logic             btn_level;
  logic [DEB_W-1:0] deb_cnt;

  logic        slot_end;
  logic        frame;
  logic        blank;
  logic [15:0] sel_data;
  logic [1:0]  next_page;
  logic [1:0]  cand;
  logic        btn_mismatch;
  logic        btn_accept;
  logic        press;
  logic        advance;
  logic [3:0]  nib;

  assign slot_end     = (cnt == CNT_LAST);
  assign frame        = slot_end && (d == 2'd3);
  assign blank        = (cnt < BLANK_END);
  assign nib          = snap[{d, 2'b00} +: 4];

  // The accepted level flips on the DEB_CYC-th consecutive mismatching cycle;
  // the press event is taken combinationally on that same cycle.
  assign btn_mismatch = (btn_s2 != btn_level);
  assign btn_accept   = btn_mismatch && (deb_cnt == DEB_LAST);
  assign press        = btn_accept && btn_s2;

  // A page whose valid bit dropped is abandoned at the next frame boundary.
  assign advance      = press || (frame && !page_valid[page_sel]);

  always_comb begin
    case (page_sel)
      2'd0:    sel_data = page_data0;
      2'd1:    sel_data = page_data1;
      2'd2:    sel_data = page_data2;
      default: sel_data = page_data3;
    endcase
  end

  // Nearest valid page after the current one; scanning from the farthest
  // candidate down lets the closest match win. Unchanged if none is valid.
  always_comb begin
    next_page = page_sel;
    cand      = page_sel;
    for (int i = 3; i >= 1; i--) begin
      cand = page_sel + 2'(i);
      if (page_valid[cand]) next_page = cand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      d          <= 2'd0;
      snap       <= 16'h0000;
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_level  <= 1'b0;
      deb_cnt    <= '0;
      page_sel   <= 2'd0;
      frame_tick <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
    end else begin
      // Scan prescaler and digit index
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) d <= d + 2'd1;

      frame_tick <= frame;

      // Snapshot uses the page selected in this cycle, before any advance
      if (frame && !freeze)
        snap <= (page_valid == 4'b0000) ? 16'h0000 : sel_data;

      // Debounce
      btn_s1 <= page_btn;
      btn_s2 <= btn_s1;
      if (!btn_mismatch || btn_accept) deb_cnt <= '0;
      else                             deb_cnt <= deb_cnt + 1'b1;
      if (btn_accept) btn_level <= btn_s2;

      if (advance) page_sel <= next_page;

      // Display pins, one cycle behind (cnt, d)
      an  <= blank ? 4'b1111 : ~(4'b0001 << d);
      seg <= glyph(nib);
      if (blank)       dp <= 1'b1;
      else if (freeze) dp <= (d != 2'd3);
      else             dp <= (d != page_sel);
    end
  end

endmodule
`default_nettype wire
